// File: rtl/lsu_sub_word.sv
// rtl/lsu_sub_word.sv - byte/half/word load-store unit with read-modify-write sub-word stores
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module lsu_sub_word #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wd_q, wd_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;

  logic        req_err;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] ext;
  logic [31:0] merged;

  always_comb begin
    req_err = (req_size == 2'b11) || (req_addr >= 32'(MEM_WORDS * 4));
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_size == 2'b01) && req_addr[0]) req_err = 1'b1;
    if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
`endif
  end

  // Lane selection ignores addr[0] for halves, so untrapped misalignment clears it.
  assign byte_sh = {addr_q[1:0], 3'b000};
  assign half_sh = {addr_q[1], 4'b0000};
  assign sel_b   = 8'(mem_rd >> byte_sh);
  assign sel_h   = 16'(mem_rd >> half_sh);

  always_comb begin
    ext    = mem_rd;
    merged = wdata_q;
    case (size_q)
      2'b00: begin
        ext    = {{24{~uns_q & sel_b[7]}}, sel_b};
        merged = (mem_rd & ~(32'h0000_00FF << byte_sh)) | ({24'b0, wdata_q[7:0]} << byte_sh);
      end
      2'b01: begin
        ext    = {{16{~uns_q & sel_h[15]}}, sel_h};
        merged = (mem_rd & ~(32'h0000_FFFF << half_sh)) | ({16'b0, wdata_q[15:0]} << half_sh);
      end
      default: begin
        ext    = mem_rd;
        merged = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wd_d    = wd_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          err_d   = req_err;
          rdata_d = 32'h0;
          if (req_err) begin
            state_d = RESP;
          end else if (req_we && (req_size == 2'b10)) begin
            wd_d    = req_wdata;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          wd_d    = merged;
          state_d = WRITE;
        end else begin
          rdata_d = ext;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      wd_q    <= 32'h0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wd_q    <= wd_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
    end
  end

  // Write enable decodes straight from state so an async reset drops it before the edge.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign mem_we     = (state_q == WRITE);
  assign mem_a      = {addr_q[31:2], 2'b00};
  assign mem_wd     = wd_q;

endmodule

// File: tb/tb_lsu_sub_word.sv
// tb/tb_lsu_sub_word.sv - randomized check of lsu_sub_word against a request-level memory model
// Honours LSU_MISALIGN_TRAP_EN to match the DUT build.
module tb_lsu_sub_word;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  lsu_sub_word #(.MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [64];
  assign mem_rd = ram[mem_a[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_a[7:2]] <= mem_wd;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit manual = 1'b1;

  logic [31:0] ref_mem [64];
  int          issued = 0;
  int          served = 0;
  int          acc_cyc;
  int          e_lat;
  bit          e_err, e_we, e_lit, e_lit_err;
  logic [31:0] e_rdata, e_addr, e_wd, e_lit_rdata;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] s);
    bit e;
    e = (s == 2'b11) || (a >= 32'd256);
`ifdef LSU_MISALIGN_TRAP_EN
    if (s == 2'b01 && a[0]) e = 1'b1;
    if (s == 2'b10 && a[1:0] != 2'b00) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic int byte_off(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'b00) return int'(a % 4);
    if (s == 2'b01) return int'((a / 2) % 2) * 2;
    return 0;
  endfunction

  // Request-level model: update ref_mem and publish what the DUT must show.
  task automatic send(input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] s, input bit uns,
                      input bit lit, input logic [31:0] lit_rd, input bit lit_err);
    int n;
    int nb;
    int off;
    logic [63:0] w, v, mask, full;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got 0 want 1");
    end
    e_err = model_err(a, s);
    e_we = we;
    e_addr = a;
    e_lit = lit; e_lit_rdata = lit_rd; e_lit_err = lit_err;
    e_rdata = 32'h0;
    e_wd = 32'h0;
    nb = nbytes(s);
    off = byte_off(a, s);
    if (e_err) begin
      e_lat = 1;
    end else begin
      w = {32'h0, ref_mem[a[7:2]]};
      full = (64'd1 << (8 * nb)) - 64'd1;
      if (we) begin
        mask = full << (8 * off);
        v = (w & ~mask) | (({32'h0, wd} << (8 * off)) & mask);
        ref_mem[a[7:2]] = v[31:0];
        e_wd = v[31:0];
        e_lat = (nb == 4) ? 2 : 3;
      end else begin
        v = (w >> (8 * off)) & full;
        if (!uns && nb < 4 && v >= (64'd1 << (8 * nb - 1)))
          v = v + (64'd1 << 32) - (64'd1 << (8 * nb));
        e_rdata = v[31:0];
        e_lat = 2;
      end
    end
    acc_cyc = cyc;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    req_size = s; req_unsigned = uns;
    issued++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom); req_we = 1'($urandom);
    n = 0;
    while (served != issued && n < 20) begin @(posedge clk); #1; n++; end
    if (served != issued) begin
      tests++; fails++;
      $display("FAIL resp_timeout: got no response want response");
    end
  endtask

  always @(negedge clk) begin
    bit pend;
    if (!manual && rst_n) begin
      pend = (issued != served);
      chk("req_ready", {31'b0, req_ready}, {31'b0, !(pend && cyc > acc_cyc)});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, pend && cyc == acc_cyc + e_lat});
      chk("mem_we", {31'b0, mem_we},
          {31'b0, pend && !e_err && e_we && cyc == acc_cyc + e_lat - 1});
      if (pend && !e_err && cyc > acc_cyc && cyc < acc_cyc + e_lat)
        chk("mem_a", mem_a, {e_addr[31:2], 2'b00});
      if (pend && !e_err && e_we && cyc == acc_cyc + e_lat - 1)
        chk("mem_wd", mem_wd, e_wd);
      if (pend && cyc == acc_cyc + e_lat) begin
        chk("resp_err", {31'b0, resp_err}, {31'b0, e_err});
        chk("resp_rdata", resp_rdata, e_rdata);
        if (e_lit) begin
          chk("lit_rdata", resp_rdata, e_lit_rdata);
          chk("lit_err", {31'b0, resp_err}, {31'b0, e_lit_err});
        end
        served++;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    manual = 1'b0;

    for (int i = 0; i < 64; i++) send(1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);

    send(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
    send(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    send(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
    send(1'b1, 32'h21, 32'h000000AA, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("ram_byte_merge", ram[8], 32'h1122AA44);
    send(1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 1'b1, 32'hFFFFFFAA, 1'b0);
    send(1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 1'b1, 32'h000000AA, 1'b0);
    send(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
    send(1'b1, 32'h22, 32'h00008001, 2'b01, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("ram_half_merge", ram[8], 32'h80013344);
    send(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 1'b1, 32'hFFFF8001, 1'b0);
    send(1'b1, 32'h100, 32'h12345678, 2'b10, 1'b0, 1'b1, 32'h0, 1'b1);
    send(1'b1, 32'h0, 32'h12345678, 2'b11, 1'b0, 1'b1, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
    send(1'b0, 32'h23, 32'h0, 2'b01, 1'b0, 1'b1, 32'h0, 1'b1);
`else
    send(1'b0, 32'h23, 32'h0, 2'b01, 1'b0, 1'b1, 32'hFFFF8001, 1'b0);
`endif

    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] a;
      logic [1:0] s;
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else if (r == 1) a = 32'(256 + $urandom_range(0, 16));
      else a = 32'($urandom_range(0, 255));
      r = $urandom_range(0, 7);
      s = (r < 7) ? 2'(r % 3) : 2'b11;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      send(1'($urandom), a, $urandom, s, 1'($urandom), 1'b0, 32'h0, 1'b0);
    end

    // Reset during the WRITE cycle of a sub-word store must leave RAM untouched.
    manual = 1'b1;
    chk("abort_ready", {31'b0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
    req_size = 2'b00; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_read_we", {31'b0, mem_we}, 32'h0);
    @(posedge clk); #1;
    chk("abort_write_we", {31'b0, mem_we}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_drop", {31'b0, mem_we}, 32'h0);
    chk("abort_ready_rst", {31'b0, req_ready}, 32'h1);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_resp", {31'b0, resp_valid}, 32'h0);
    chk("abort_ram", ram[8], ref_mem[8]);
    manual = 1'b0;

    send(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 64; i++) chk("final_ram", ram[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
